// File: rtl/gather_rr_pkg.sv
// gather_pkg: shared channel limits and index type for the gather_rr round-robin merger.
package gather_pkg;

    localparam int GATHER_MAX_CHANNELS = 16;

    typedef logic [3:0] chan_idx_t;

endpackage

// File: rtl/gather_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant over req_i, gated by en_i, with the rotating priority pointer.
module rr_arbiter
    import gather_pkg::*;
#(
    parameter int channels = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [channels-1:0] req_i,
    input  logic                en_i,
    output logic [channels-1:0] grant_o,
    output logic [3:0]          gidx_o
);

    chan_idx_t           ptr_q, ptr_d;
    logic [channels-1:0] hi, sel;

    // Requests at or above ptr win first; otherwise wrap to the lowest requester.
    always_comb begin
        hi = '0;
        for (int i = 0; i < channels; i++) hi[i] = req_i[i] && (i >= int'(ptr_q));
        sel = |hi ? hi : req_i;
        grant_o = '0;
        gidx_o = '0;
        for (int i = channels - 1; i >= 0; i--)
            if (sel[i]) begin
                grant_o = '0;
                grant_o[i] = en_i;
                gidx_o = chan_idx_t'(i);
            end
    end

    assign ptr_d = (en_i && |req_i)
                 ? ((gidx_o == chan_idx_t'(channels - 1)) ? '0 : chan_idx_t'(gidx_o + 4'd1))
                 : ptr_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) ptr_q <= '0;
        else ptr_q <= ptr_d;

endmodule

// File: rtl/gather_rr.sv
// gather_rr: merges N valid/ready channels into one registered stream, round-robin fair.
// Define GATHER_RR_TAG_EN to add the s_chan source-index output.
module gather_rr
    import gather_pkg::*;
#(
    parameter int width    = 8,
    parameter int channels = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [channels*width-1:0] m_data,
    input  logic [channels-1:0]       m_valid,
    output logic [channels-1:0]       m_ready,
    output logic [width-1:0]          s_data,
    output logic                      s_valid,
    input  logic                      s_ready
`ifdef GATHER_RR_TAG_EN
    ,
    output logic [3:0]                s_chan
`endif
);

    logic             ld, xfer, s_valid_q;
    logic [width-1:0] s_data_q, s_data_d;
    chan_idx_t        gidx;

    assign ld = !s_valid_q || s_ready;

    // Enable is also killed by reset so m_ready drops as soon as reset asserts.
    rr_arbiter #(.channels(channels)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req_i   (m_valid),
        .en_i    (ld && !reset),
        .grant_o (m_ready),
        .gidx_o  (gidx)
    );

    assign xfer = |m_ready;

    always_comb begin
        s_data_d = '0;
        for (int i = 0; i < channels; i++)
            if (gidx == chan_idx_t'(i)) s_data_d = m_data[i*width +: width];
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            s_valid_q <= 1'b0;
            s_data_q <= '0;
        end else if (ld) begin
            s_valid_q <= xfer;
            if (xfer) s_data_q <= s_data_d;
        end

    assign s_valid = s_valid_q;
    assign s_data = s_data_q;

`ifdef GATHER_RR_TAG_EN
    chan_idx_t s_chan_q;

    always_ff @(posedge clock or posedge reset)
        if (reset) s_chan_q <= '0;
        else if (ld && xfer) s_chan_q <= gidx;

    assign s_chan = s_chan_q;
`endif

endmodule

// File: tb/tb_gather_rr.sv
// tb_gather_rr: scoreboard bench for gather_rr (4-channel model-checked DUT plus a 3-channel order check).
module tb_gather_rr;

    localparam int W = 8;
    localparam int C = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [C*W-1:0] m_data;
    logic [C-1:0]   m_valid = '0, m_ready;
    logic [W-1:0]   s_data;
    logic           s_valid, s_ready = 1'b0;
    logic [3*W-1:0] m_data3;
    logic [2:0]     m_valid3 = 3'b111, m_ready3;
    logic [W-1:0]   s_data3;
    logic           s_valid3;
`ifdef GATHER_RR_TAG_EN
    logic [3:0]     s_chan, s_chan3;
`endif

    always #5 clock = ~clock;

    gather_rr #(.width(W), .channels(C)) u_dut (
        .clock(clock), .reset(reset), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready)
`ifdef GATHER_RR_TAG_EN
        , .s_chan(s_chan)
`endif
    );

    gather_rr #(.width(W), .channels(3)) u_dut3 (
        .clock(clock), .reset(reset), .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready3),
        .s_data(s_data3), .s_valid(s_valid3), .s_ready(1'b1)
`ifdef GATHER_RR_TAG_EN
        , .s_chan(s_chan3)
`endif
    );

    int         n_run = 0, n_fail = 0;
    int         mptr = 0, pend = -1;
    logic       msv = 1'b0;
    logic [5:0] cnt [C];
    int         waitc [C];
    logic [7:0] exp_q [$];

    always_comb begin
        for (int i = 0; i < C; i++) m_data[i*W +: W] = {2'(i), cnt[i]};
        for (int i = 0; i < 3; i++) m_data3[i*W +: W] = {2'(i), 6'd0};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [C-1:0] rr(input logic [C-1:0] v, input int p);
        for (int k = 0; k < C; k++) if (v[(p + k) % C]) return C'(1) << ((p + k) % C);
        return '0;
    endfunction

    task automatic apply_pending();
        if (pend >= 0) cnt[pend] = cnt[pend] + 6'd1;
        pend = -1;
    endtask

    task automatic step(input logic [C-1:0] v, input logic r);
        logic          ld;
        logic [C-1:0]  g;
        @(posedge clock);
        #1;
        apply_pending();
        m_valid = v;
        s_ready = r;
        @(negedge clock);
        ld = !msv || r;
        g = ld ? rr(v, mptr) : '0;
        check("m_ready", m_ready, g);
        check("s_valid", s_valid, msv);
        if (msv) begin
            if (exp_q.size() == 0) check("underflow", 1, 0);
            else begin
                check("s_data", s_data, exp_q[0]);
`ifdef GATHER_RR_TAG_EN
                check("s_chan", s_chan, exp_q[0][7:6]);
`endif
                if (r) void'(exp_q.pop_front());
            end
        end
        for (int i = 0; i < C; i++) begin
            if (g[i]) begin
                check("fair", waitc[i] < C, 1);
                waitc[i] = 0;
                exp_q.push_back({2'(i), cnt[i]});
                pend = i;
                mptr = (i + 1) % C;
            end else if (v[i] && g != '0) waitc[i]++;
            else if (!v[i]) waitc[i] = 0;
        end
        if (ld) msv = (g != '0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        apply_pending();
        reset = 1'b1;
        m_valid = '1;
        s_ready = 1'b0;
        #1;
        check("rst_svalid", s_valid, 0);
        check("rst_mready", m_ready, 0);
        @(negedge clock);
        @(negedge clock);
        check("rst_sdata", s_data, 0);
        check("rst_mready_hold", m_ready, 0);
`ifdef GATHER_RR_TAG_EN
        check("rst_schan", s_chan, 0);
`endif
        m_valid = '0;
        reset = 1'b0;
        msv = 1'b0;
        mptr = 0;
        exp_q.delete();
        for (int i = 0; i < C; i++) waitc[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < C; i++) begin
            cnt[i] = '0;
            waitc[i] = 0;
        end
        cnt[2] = 6'h25;
        do_reset();
        s_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("ch3_valid", s_valid3, 1);
            check("ch3_order", s_data3[7:6], 32'(k % 3));
        end
        // lone channel 2 carrying 8'hA5
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        check("a5", s_data, 8'hA5);
        do_reset();
        for (int k = 0; k < 8; k++) step('1, 1'b1);
        for (int k = 0; k < 3; k++) step('1, 1'b0);
        step('1, 1'b1);
        step('1, 1'b1);
        step('1, 1'b0);
        do_reset();
        step(4'b0110, 1'b1);
        step(4'b0110, 1'b1);
        for (int c = 0; c < 1000; c++) begin
            logic [C-1:0] v;
            for (int i = 0; i < C; i++) v[i] = (c % (i + 3)) != 0;
            step(v, (c % 5) != 0);
        end
        step('0, 1'b1);
        step('0, 1'b1);
        check("drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
